dds_sweep_ctrl: RTL and testbench
=================================

Name: dds_sweep_ctrl

Overview:
Frequency-sweep scheduler that drives the fword/pword inputs of the dds block. It accepts a sweep configuration through a valid/ready handshake: start, stop and step tuning words, a dwell time, a phase word and a mode. On start it steps the DDS tuning word from start to stop, holding each value for a programmable dwell, then completes once or repeats. It sits between the register/host interface and the dds core in the same clock domain.

Parameters:
DEPTH_BITWIDTH, 8, width of the tuning/phase words. Must match dds DEPTH_BITWIDTH.
DWELL_BITWIDTH, 16, width of the dwell counter and cfg_dwell.

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  reset, asynchronous assert, active-low
cfg_valid  in  1  configuration word valid
cfg_ready  out  1  controller can accept configuration
cfg_f_start  in  DEPTH_BITWIDTH  first tuning word
cfg_f_stop  in  DEPTH_BITWIDTH  last tuning word
cfg_f_step  in  DEPTH_BITWIDTH  step magnitude; 0 is treated as 1
cfg_dwell  in  DWELL_BITWIDTH  each frequency is held cfg_dwell+1 cycles
cfg_pword  in  DEPTH_BITWIDTH  phase offset applied during the sweep
cfg_repeat  in  1  0 = single sweep, 1 = restart at f_start after f_stop
start  in  1  one-cycle request to begin a sweep
abort  in  1  one-cycle request to stop immediately
fword  out  DEPTH_BITWIDTH  to dds fword, registered
pword  out  DEPTH_BITWIDTH  to dds pword, registered
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at normal completion

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values: fword=0, pword=0, busy=0, done=0, cfg_ready=1, state=IDLE, cfg_loaded=0. All shadow registers and the dwell counter are cleared.
- States:
  - IDLE: cfg_ready=1. A handshake (cfg_valid & cfg_ready) latches all cfg_* into shadow registers and sets cfg_loaded=1.
  - RUN: cfg_ready=0, busy=1.
- Start: in IDLE, start & cfg_loaded & !cfg_valid & !abort moves to RUN. In the next cycle fword=f_start, pword=cfg_pword (shadow), busy=1, dwell_cnt=0.
- Start is ignored in these cases:
  - while in RUN;
  - when no configuration has been loaded;
  - in a cycle where a cfg handshake occurs (the new config is captured, the sweep does not start).
- Direction: up if f_stop >= f_start, else down. Fixed at start.
- RUN, dwell_cnt < dwell: dwell_cnt increments, fword holds.
- RUN, dwell_cnt == dwell: dwell_cnt returns to 0, and:
  - fword != f_stop: fword advances by step in the sweep direction, clamped to f_stop. Overshoot is detected with DEPTH_BITWIDTH+1-bit unsigned arithmetic, so fword never wraps past 0 or 2^DEPTH_BITWIDTH-1.
  - fword == f_stop and repeat=1: fword = f_start, busy stays 1.
  - fword == f_stop and repeat=0: go to IDLE. Next cycle busy=0 and done=1 for exactly one cycle. fword and pword hold their final values.
- Timing:
  - Each frequency, including f_start and f_stop, is on fword for exactly dwell+1 cycles.
  - A single sweep occupies N*(dwell+1) busy cycles, N = number of distinct words.
- f_start == f_stop: one word is output for dwell+1 cycles, then done (repeat=0) or the word is held indefinitely (repeat=1).
- Abort:
  - In RUN, abort moves to IDLE in the next cycle: busy=0, done stays 0, fword/pword hold their current values, dwell_cnt=0.
  - Abort wins over start in the same cycle.
  - Abort in IDLE has no effect.
- Configuration during RUN: cfg_ready=0 and cfg_valid is not consumed. The shadow registers stay stable for the whole sweep.
- Reset mid-sweep returns immediately to the reset values. The config must be reloaded before the next start.
- cfg_loaded persists across sweeps, so repeated starts reuse the last config.

Test Plan:
- DEPTH=8, f_start=2, f_stop=10, step=3, dwell=1, repeat=0, start -> fword 2,2,5,5,8,8,10,10 on consecutive cycles; busy high 8 cycles; done pulses one cycle as busy falls; fword holds 10.
- Down sweep: f_start=200, f_stop=190, step=4, dwell=0 -> fword 200,196,192,190, then done. Step 0 with 3→5, dwell=0 -> 3,4,5.
- Repeat: f_start=250, f_stop=255, step=4, dwell=0, repeat=1 -> 250,254,255,250,254,255… with no 8-bit wrap and done never asserted; abort -> busy=0 next cycle, fword holds, done=0.
- Handshake:
  - cfg_valid in RUN -> cfg_ready=0 and the sweep is unaffected.
  - start before any config -> no response.
  - cfg_valid and start in the same IDLE cycle -> config captured, busy stays 0; a later start uses the new config.
- Boundary: f_start=f_stop=7, dwell=3, repeat=0 -> fword=7 for 4 cycles, then done. pword=cfg_pword=64 appears with the first fword.
- Reset: rstn low mid-sweep -> fword=0, pword=0, busy=0 asynchronously. After release, start without reload is ignored.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep scheduler feeding the fword/pword inputs of
// the dds core. Takes a sweep configuration through a valid/ready handshake,
// then steps the tuning word from f_start to f_stop, holding each word for
// dwell+1 cycles, and either finishes with a done pulse or repeats.
module dds_sweep_ctrl #(
    parameter int DEPTH_BITWIDTH = 8,
    parameter int DWELL_BITWIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [DEPTH_BITWIDTH-1:0] cfg_f_start,
    input  logic [DEPTH_BITWIDTH-1:0] cfg_f_stop,
    input  logic [DEPTH_BITWIDTH-1:0] cfg_f_step,
    input  logic [DWELL_BITWIDTH-1:0] cfg_dwell,
    input  logic [DEPTH_BITWIDTH-1:0] cfg_pword,
    input  logic                      cfg_repeat,
    input  logic                      start,
    input  logic                      abort,
    output logic [DEPTH_BITWIDTH-1:0] fword,
    output logic [DEPTH_BITWIDTH-1:0] pword,
    output logic                      busy,
    output logic                      done
);

    localparam int W = DEPTH_BITWIDTH;
    localparam logic [W-1:0]              STEP_ONE  = 1;
    localparam logic [DWELL_BITWIDTH-1:0] DWELL_ONE = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e state_q, state_d;

    // Shadow copy of the configuration, stable for the whole sweep
    logic [W-1:0]              f_start_q, f_stop_q, f_step_q, pword_cfg_q;
    logic [DWELL_BITWIDTH-1:0] dwell_q;
    logic                      repeat_q;
    logic                      cfg_loaded_q;

    // Sweep datapath
    logic [W-1:0]              fword_q, fword_d;
    logic [W-1:0]              pword_q, pword_d;
    logic [DWELL_BITWIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
    logic                      dir_up_q, dir_up_d;
    logic                      done_q, done_d;

    logic                      cfg_fire;
    logic                      start_go;
    logic                      dwell_end;
    logic                      at_stop;
    logic [W-1:0]              step_eff;
    logic [W:0]                sum_up;
    logic [W:0]                diff_dn;
    logic [W-1:0]              next_word;

    assign cfg_fire  = cfg_valid & cfg_ready;
    // A handshake in the same cycle wins: the new config is captured, no start
    assign start_go  = (state_q == IDLE) & start & cfg_loaded_q & ~cfg_valid & ~abort;
    assign dwell_end = (dwell_cnt_q == dwell_q);
    assign at_stop   = (fword_q == f_stop_q);

    // One extra bit on the step arithmetic exposes overshoot past either end of
    // the word range, so the clamp to f_stop never sees a wrapped value.
    assign step_eff = (f_step_q == '0) ? STEP_ONE : f_step_q;
    assign sum_up   = {1'b0, fword_q} + {1'b0, step_eff};
    assign diff_dn  = {1'b0, fword_q} - {1'b0, step_eff};

    // Next tuning word in the sweep direction, clamped to f_stop
    always_comb begin
        next_word = fword_q;
        if (dir_up_q) begin
            next_word = (sum_up >= {1'b0, f_stop_q}) ? f_stop_q : sum_up[W-1:0];
        end else begin
            next_word = (diff_dn[W] || (diff_dn[W-1:0] <= f_stop_q)) ? f_stop_q : diff_dn[W-1:0];
        end
    end

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: start, abort and normal completion
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_go) state_d = RUN;
            RUN: begin
                if (abort)                                state_d = IDLE;
                else if (dwell_end && at_stop && !repeat_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        cfg_ready = (state_q == IDLE);
        busy      = (state_q == RUN);
    end

    // Shadow registers capture the configuration on a handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f_start_q    <= '0;
            f_stop_q     <= '0;
            f_step_q     <= '0;
            dwell_q      <= '0;
            pword_cfg_q  <= '0;
            repeat_q     <= 1'b0;
            cfg_loaded_q <= 1'b0;
        end else if (cfg_fire) begin
            f_start_q    <= cfg_f_start;
            f_stop_q     <= cfg_f_stop;
            f_step_q     <= cfg_f_step;
            dwell_q      <= cfg_dwell;
            pword_cfg_q  <= cfg_pword;
            repeat_q     <= cfg_repeat;
            cfg_loaded_q <= 1'b1;
        end
    end

    // Sweep datapath: dwell counting, word stepping, wrap-around and done pulse
    always_comb begin
        fword_d     = fword_q;
        pword_d     = pword_q;
        dwell_cnt_d = dwell_cnt_q;
        dir_up_d    = dir_up_q;
        done_d      = 1'b0;
        if (start_go) begin
            fword_d     = f_start_q;
            pword_d     = pword_cfg_q;
            dwell_cnt_d = '0;
            dir_up_d    = (f_stop_q >= f_start_q);
        end else if (state_q == RUN) begin
            if (abort) begin
                dwell_cnt_d = '0;
            end else if (!dwell_end) begin
                dwell_cnt_d = dwell_cnt_q + DWELL_ONE;
            end else begin
                dwell_cnt_d = '0;
                if (!at_stop)      fword_d = next_word;
                else if (repeat_q) fword_d = f_start_q;
                else               done_d  = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fword_q     <= '0;
            pword_q     <= '0;
            dwell_cnt_q <= '0;
            dir_up_q    <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            fword_q     <= fword_d;
            pword_q     <= pword_d;
            dwell_cnt_q <= dwell_cnt_d;
            dir_up_q    <= dir_up_d;
            done_q      <= done_d;
        end
    end

    assign fword = fword_q;
    assign pword = pword_q;
    assign done  = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Testbench for dds_sweep_ctrl: a scoreboard queue holds the expected
// per-cycle outputs pushed when stimulus is driven; a monitor pops and
// compares one entry per clock, shortly after the rising edge.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_f_start, cfg_f_stop, cfg_f_step, cfg_pword;
    logic [15:0] cfg_dwell;
    logic        cfg_repeat;
    logic        start, abort;
    logic [7:0]  fword, pword;
    logic        busy, done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [7:0] fword;
        logic [7:0] pword;
        logic       busy;
        logic       done;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    int   last_f = 0;
    int   last_p = 0;

    dds_sweep_ctrl #(
        .DEPTH_BITWIDTH(8),
        .DWELL_BITWIDTH(16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_f_start(cfg_f_start),
        .cfg_f_stop (cfg_f_stop),
        .cfg_f_step (cfg_f_step),
        .cfg_dwell  (cfg_dwell),
        .cfg_pword  (cfg_pword),
        .cfg_repeat (cfg_repeat),
        .start      (start),
        .abort      (abort),
        .fword      (fword),
        .pword      (pword),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Monitor: one scoreboard entry per clock, sampled 1 time unit after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("fword",     32'(fword),     32'(e.fword));
                check("pword",     32'(pword),     32'(e.pword));
                check("busy",      32'(busy),      32'(e.busy));
                check("done",      32'(done),      32'(e.done));
                check("cfg_ready", 32'(cfg_ready), 32'(e.ready));
            end
        end
    end

    task automatic push_exp(input int f, input int p, input bit b, input bit d, input bit r);
        exp_t e;
        e.fword = 8'(f);
        e.pword = 8'(p);
        e.busy  = b;
        e.done  = d;
        e.ready = r;
        exp_q.push_back(e);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push_exp(last_f, last_p, 1'b0, 1'b0, 1'b1);
    endtask

    // Reference sweep model: each word held dw+1 cycles, clamped at fe
    task automatic push_sweep(input int fs, input int fe, input int st, input int dw,
                              input int pw, input bit rep, input int max_n);
        int w   = fs;
        int n   = 0;
        int stp = (st == 0) ? 1 : st;
        bit up  = (fe >= fs);
        bit fin = 1'b0;
        while (!fin && n < max_n) begin
            for (int k = 0; k <= dw && n < max_n; k++) begin
                push_exp(w, pw, 1'b1, 1'b0, 1'b0);
                last_f = w;
                n++;
            end
            if (w == fe) begin
                if (rep) w = fs;
                else     fin = 1'b1;
            end else if (up) begin
                w = w + stp;
                if (w > fe) w = fe;
            end else begin
                w = w - stp;
                if (w < fe) w = fe;
            end
        end
        last_p = pw;
        if (!rep) begin
            push_exp(last_f, pw, 1'b0, 1'b1, 1'b1);
            push_exp(last_f, pw, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic drain();
        int budget = 500;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic load_cfg(input int fs, input int fe, input int st, input int dw,
                            input int pw, input bit rep);
        @(negedge clk);
        cfg_valid   = 1'b1;
        cfg_f_start = 8'(fs);
        cfg_f_stop  = 8'(fe);
        cfg_f_step  = 8'(st);
        cfg_dwell   = 16'(dw);
        cfg_pword   = 8'(pw);
        cfg_repeat  = rep;
        @(negedge clk);
        cfg_valid   = 1'b0;
    endtask

    task automatic run_sweep(input int fs, input int fe, input int st, input int dw,
                             input int pw, input bit rep, input int max_n);
        load_cfg(fs, fe, st, dw, pw, rep);
        @(negedge clk);
        start = 1'b1;
        push_sweep(fs, fe, st, dw, pw, rep, max_n);
        @(negedge clk);
        start = 1'b0;
        drain();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_fword"}, 32'(fword),     32'd0);
        check({tag, "_pword"}, 32'(pword),     32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
        check({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn        = 1'b0;
        cfg_valid   = 1'b0;
        cfg_f_start = '0;
        cfg_f_stop  = '0;
        cfg_f_step  = '0;
        cfg_dwell   = '0;
        cfg_pword   = '0;
        cfg_repeat  = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Start with no configuration loaded: nothing happens
        @(negedge clk);
        start = 1'b1;
        push_idle(3);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Up sweep 2..10 step 3 dwell 1, with cfg_valid held during RUN
        load_cfg(2, 10, 3, 1, 8'h11, 1'b0);
        @(negedge clk);
        start = 1'b1;
        push_sweep(2, 10, 3, 1, 8'h11, 1'b0, 1000);
        @(negedge clk);
        start       = 1'b0;
        cfg_valid   = 1'b1;
        cfg_f_start = 8'd99;
        cfg_f_stop  = 8'd1;
        cfg_f_step  = 8'd7;
        cfg_dwell   = 16'd5;
        cfg_pword   = 8'd33;
        drain();
        cfg_valid = 1'b0;

        // Down sweep with clamp, then step 0 treated as 1
        run_sweep(200, 190, 4, 0, 8'h22, 1'b0, 1000);
        run_sweep(3, 5, 0, 0, 8'h33, 1'b0, 1000);

        // cfg handshake and start in the same IDLE cycle: config captured, no start
        @(negedge clk);
        cfg_valid   = 1'b1;
        start       = 1'b1;
        cfg_f_start = 8'd20;
        cfg_f_stop  = 8'd22;
        cfg_f_step  = 8'd1;
        cfg_dwell   = 16'd0;
        cfg_pword   = 8'd5;
        cfg_repeat  = 1'b0;
        push_idle(2);
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        drain();
        @(negedge clk);
        start = 1'b1;
        push_sweep(20, 22, 1, 0, 5, 1'b0, 1000);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Repeat near the top of the range, then abort
        run_sweep(250, 255, 4, 0, 8'h44, 1'b1, 9);
        abort = 1'b1;
        push_idle(2);
        @(negedge clk);
        abort = 1'b0;
        drain();

        // Abort in IDLE, and abort beating start
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        push_idle(3);
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        drain();

        // f_start == f_stop with dwell 3, then a restart reusing the config
        run_sweep(7, 7, 5, 3, 64, 1'b0, 1000);
        @(negedge clk);
        start = 1'b1;
        push_sweep(7, 7, 5, 3, 64, 1'b0, 1000);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset mid-sweep, then start without reload is ignored
        load_cfg(2, 10, 3, 1, 8'h55, 1'b0);
        @(negedge clk);
        start = 1'b1;
        push_sweep(2, 10, 3, 1, 8'h55, 1'b0, 1000);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midsweep_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check_reset_values("async_reset");
        exp_q.delete();
        last_f = 0;
        last_p = 0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        start = 1'b1;
        push_idle(3);
        @(negedge clk);
        start = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
